// File: rtl/idct_pkg.sv
// Shared constants and types for the IDCT front-end: array geometry,
// coefficient width and the feeder's read-side state encoding.
package idct_pkg;

  localparam int unsigned IDCT_N = 4;
  localparam int unsigned COEF_W = 8;

  typedef logic [IDCT_N-1:0][COEF_W-1:0] coef_row_t;

  typedef enum logic {
    IDLE,
    DRAIN
  } feed_state_t;

endpackage

// File: rtl/idct_skew_line.sv
// Per-lane delay line: W-bit data plus its valid bit shifted through DEPTH
// registered stages, so every lane output comes straight from a flop.
module idct_skew_line #(
  parameter int unsigned   W        = 8,
  parameter int unsigned   DEPTH    = 1,
  parameter logic [W-1:0]  IDLE_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic [W-1:0] out_data,
  output logic         out_valid
);

  logic [W-1:0] data_q  [DEPTH];
  logic         valid_q [DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        data_q[i]  <= IDLE_VAL;
        valid_q[i] <= 1'b0;
      end
    end else begin
      data_q[0]  <= in_data;
      valid_q[0] <= in_valid;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        data_q[i]  <= data_q[i-1];
        valid_q[i] <= valid_q[i-1];
      end
    end
  end

  assign out_data  = data_q[DEPTH-1];
  assign out_valid = valid_q[DEPTH-1];

endmodule

// File: rtl/idct_skew_feeder.sv
// Ping-pong buffered 4x4 block feeder: collects a raster byte stream and
// replays each block row by row as a diagonal wavefront across four lanes.
module idct_skew_feeder
  import idct_pkg::*;
#(
  parameter int unsigned       DATA_W   = COEF_W,
  parameter logic [DATA_W-1:0] IDLE_VAL = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] d_in_1,
  output logic [DATA_W-1:0] d_in_2,
  output logic [DATA_W-1:0] d_in_3,
  output logic [DATA_W-1:0] d_in_4,
  output logic [IDCT_N-1:0] lane_valid,
  output logic              out_sob
);

  localparam int unsigned BLK   = IDCT_N * IDCT_N;
  localparam int unsigned CNT_W = $clog2(BLK);
  localparam int unsigned ROW_W = $clog2(IDCT_N);

  logic [DATA_W-1:0] mem [2][BLK];

  logic [CNT_W-1:0] wr_cnt;
  logic             wr_bank;
  logic             rd_bank, rd_bank_nxt;
  logic [1:0]       full, full_set, full_clr;
  logic [ROW_W-1:0] row, row_nxt;
  feed_state_t      state, state_nxt;
  logic             issue;
  logic             accept;
  logic             last_beat;

  logic [DATA_W-1:0] lane_data [IDCT_N];

  // Write side
  assign s_ready   = ~full[wr_bank];
  assign accept    = s_valid & s_ready;
  assign last_beat = (wr_cnt == CNT_W'(BLK - 1));

  always_comb begin
    full_set = '0;
    if (accept && last_beat) full_set[wr_bank] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_cnt  <= '0;
      wr_bank <= 1'b0;
    end else if (accept) begin
      wr_cnt <= wr_cnt + 1'b1;
      if (last_beat) wr_bank <= ~wr_bank;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wr_bank][wr_cnt] <= s_data;
  end

  // Writer sets and reader clears always address different banks, so both apply.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) full <= '0;
    else        full <= (full | full_set) & ~full_clr;
  end

  // Read FSM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      row     <= '0;
      rd_bank <= 1'b0;
    end else begin
      state   <= state_nxt;
      row     <= row_nxt;
      rd_bank <= rd_bank_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    row_nxt     = row;
    rd_bank_nxt = rd_bank;
    full_clr    = '0;
    issue       = 1'b0;
    case (state)
      IDLE: begin
        if (full[rd_bank]) begin
          state_nxt = DRAIN;
          row_nxt   = '0;
        end
      end
      DRAIN: begin
        issue   = 1'b1;
        row_nxt = row + 1'b1;
        if (row == ROW_W'(IDCT_N - 1)) begin
          full_clr[rd_bank] = 1'b1;
          rd_bank_nxt       = ~rd_bank;
          row_nxt           = '0;
          state_nxt         = full[~rd_bank] ? DRAIN : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Skew stage: lane k gets k+1 flops; idle lanes are loaded with IDLE_VAL.
  for (genvar k = 0; k < IDCT_N; k++) begin : g_lane
    logic [DATA_W-1:0] issue_d;
    assign issue_d = issue ? mem[rd_bank][{row, ROW_W'(k)}] : IDLE_VAL;

    idct_skew_line #(
      .W        (DATA_W),
      .DEPTH    (k + 1),
      .IDLE_VAL (IDLE_VAL)
    ) u_line (
      .clk       (clk),
      .reset     (reset),
      .in_data   (issue_d),
      .in_valid  (issue),
      .out_data  (lane_data[k]),
      .out_valid (lane_valid[k])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) out_sob <= 1'b0;
    else        out_sob <= issue && (row == '0);
  end

  assign d_in_1 = lane_data[0];
  assign d_in_2 = lane_data[1];
  assign d_in_3 = lane_data[2];
  assign d_in_4 = lane_data[3];

endmodule

// File: tb/tb_idct_skew_feeder.sv
// Directed-plus-random bench for idct_skew_feeder: a cycle-indexed schedule of
// expected lane values is built from block completion times and checked each cycle.
module tb_idct_skew_feeder;

  localparam int MAXC = 1024;

  logic       clk     = 1'b0;
  logic       reset   = 1'b0;
  logic [7:0] s_data  = '0;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [7:0] d_in_1, d_in_2, d_in_3, d_in_4;
  logic [3:0] lane_valid;
  logic       out_sob;

  int ncomp = 0;
  int nfail = 0;
  int cyc   = 0;

  logic [7:0] exp_d   [MAXC][4];
  logic [3:0] exp_v   [MAXC];
  logic       exp_sob [MAXC];
  logic [7:0] blk     [16];
  int         wcnt   = 0;
  int         prev_s = -100;

  idct_skew_feeder #(
    .DATA_W   (8),
    .IDLE_VAL (8'd0)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .d_in_1     (d_in_1),
    .d_in_2     (d_in_2),
    .d_in_3     (d_in_3),
    .d_in_4     (d_in_4),
    .lane_valid (lane_valid),
    .out_sob    (out_sob)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish before 200000");
    $fatal(1, "bench timed out");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    ncomp++;
    assert (obs === expv)
    else begin
      nfail++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, expv);
    end
  endtask

  task automatic check_cycle();
    chk("d_in_1", 32'(d_in_1), 32'(exp_d[cyc][0]));
    chk("d_in_2", 32'(d_in_2), 32'(exp_d[cyc][1]));
    chk("d_in_3", 32'(d_in_3), 32'(exp_d[cyc][2]));
    chk("d_in_4", 32'(d_in_4), 32'(exp_d[cyc][3]));
    chk("lane_valid", 32'(lane_valid), 32'(exp_v[cyc]));
    chk("out_sob", 32'(out_sob), 32'(exp_sob[cyc]));
    chk("s_ready", 32'(s_ready), 32'd1);
  endtask

  // Block completed on edge e: drain start s, lane k shows row r after edge s+1+r+k.
  task automatic schedule(input int e);
    int s;
    int c;
    if (e + 1 <= prev_s + 4) s = prev_s + 4;
    else if (e + 1 > prev_s + 5) s = e + 1;
    else s = prev_s + 5;
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 4; k++) begin
        c = s + 1 + r + k;
        if (c < MAXC) begin
          exp_d[c][k] = blk[4*r + k];
          exp_v[c][k] = 1'b1;
        end
      end
    end
    if (s + 1 < MAXC) exp_sob[s+1] = 1'b1;
    prev_s = s;
  endtask

  task automatic step(input logic v, input logic [7:0] d);
    s_valid = v;
    s_data  = d;
    @(posedge clk);
    #1;
    cyc++;
    if (v && reset) begin
      blk[wcnt] = d;
      wcnt++;
      if (wcnt == 16) begin
        schedule(cyc);
        wcnt = 0;
      end
    end
    check_cycle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'($urandom));
  endtask

  // mode 0: back-to-back, 1: invalid beat between beats, 2: random 0..3 gaps
  task automatic feed(input logic [7:0] vals [16], input int mode);
    for (int i = 0; i < 16; i++) begin
      step(1'b1, vals[i]);
      if (i != 15) begin
        if (mode == 1) step(1'b0, 8'($urandom));
        else if (mode == 2) idle(int'($urandom_range(3, 0)));
      end
    end
  endtask

  task automatic do_reset(input int n);
    reset   = 1'b0;
    s_valid = 1'b0;
    wcnt    = 0;
    prev_s  = -100;
    for (int c = cyc; c < MAXC; c++) begin
      exp_v[c]   = '0;
      exp_sob[c] = 1'b0;
      for (int k = 0; k < 4; k++) exp_d[c][k] = '0;
    end
    #1;
    chk("async_rst_lane_valid", 32'(lane_valid), 32'd0);
    chk("async_rst_d_in_1", 32'(d_in_1), 32'd0);
    for (int i = 0; i < n; i++) step(1'b0, 8'($urandom));
    reset = 1'b1;
  endtask

  initial begin
    logic [7:0] v [16];

    for (int c = 0; c < MAXC; c++) begin
      exp_v[c]   = '0;
      exp_sob[c] = 1'b0;
      for (int k = 0; k < 4; k++) exp_d[c][k] = '0;
    end

    // reset state
    reset = 1'b0;
    idle(3);
    reset = 1'b1;
    idle(2);

    // single block, no gaps
    for (int i = 0; i < 16; i++) v[i] = 8'(i + 1);
    feed(v, 0);
    idle(12);

    // two continuous blocks
    feed(v, 0);
    for (int i = 0; i < 16; i++) v[i] = 8'(101 + i);
    feed(v, 0);
    idle(12);

    // s_valid toggling every other cycle
    for (int i = 0; i < 16; i++) v[i] = 8'(i + 1);
    feed(v, 1);
    idle(12);

    // alternating extremes, continuous into a random block
    for (int i = 0; i < 16; i++) v[i] = (i % 2 == 0) ? 8'd255 : 8'd0;
    feed(v, 0);
    for (int i = 0; i < 16; i++) v[i] = 8'($urandom);
    feed(v, 0);
    idle(10);

    // random data with random gaps
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 16; i++) v[i] = 8'($urandom);
      feed(v, 2);
    end
    idle(12);

    // reset after beat 9 of a partial block, then a fresh block
    for (int i = 0; i < 9; i++) step(1'b1, 8'(i + 1));
    do_reset(2);
    for (int i = 0; i < 16; i++) v[i] = 8'(50 + i);
    feed(v, 0);
    idle(12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule
